ones_thermo_gen_d: RTL and testbench



---
 rtl/ones_count_pkg.sv | 18 +
 rtl/ones_thermo_gen_d_if.sv | 27 ++
 rtl/ones_thermo_gen_d.sv | 93 +++++++++
 tb/tb_ones_thermo_gen_d.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ones_count_pkg.sv
// Shared definitions for the serial ones-counter and its thermometer-code inverse.
// The state encoding is common to both blocks so traces read the same way.
package ones_count_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 4;
  localparam int DEFAULT_COUNT_WIDTH = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_e;

endpackage

// File: rtl/ones_thermo_gen_d_if.sv
// Start/busy/done request bus of the thermometer generator.
// The master issues counts; the slave returns the expanded mask.
interface ones_thermo_gen_d_if
  import ones_count_pkg::*;
#(
  parameter int data_width  = DEFAULT_DATA_WIDTH,
  parameter int count_width = DEFAULT_COUNT_WIDTH
);

  logic                   start;
  logic [count_width-1:0] bit_count;
  logic [data_width-1:0]  data;
  logic                   busy;
  logic                   done;
  logic                   sat;

  modport master (
    output start, bit_count,
    input  data, busy, done, sat
  );

  modport slave (
    input  start, bit_count,
    output data, busy, done, sat
  );

endinterface

// File: rtl/ones_thermo_gen_d.sv
// Expands a ones count into an LSB-justified thermometer mask, one bit per clock.
// Counts above data_width are clamped to an all-ones word and flagged on sat.
module ones_thermo_gen_d
  import ones_count_pkg::*;
#(
  parameter int data_width  = DEFAULT_DATA_WIDTH,
  parameter int count_width = DEFAULT_COUNT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  ones_thermo_gen_d_if.slave  bus
);

  // Widened by one bit so a data_width equal to 2^count_width still compares correctly.
  localparam logic [count_width:0] DW_EXT = (count_width + 1)'(data_width);

  state_e                 state_q, state_d;
  logic [count_width-1:0] remaining_q, remaining_d;
  logic [data_width-1:0]  temp_q, temp_d;
  logic                   flag_q, flag_d;
  logic [data_width-1:0]  data_q, data_d;
  logic                   sat_q, sat_d;
  logic                   done_q, done_d;

  logic [count_width:0]   req_ext;
  logic                   req_over;
  logic [count_width-1:0] req_k;

  assign req_ext  = {1'b0, bus.bit_count};
  assign req_over = req_ext > DW_EXT;
  assign req_k    = req_over ? DW_EXT[count_width-1:0] : bus.bit_count;

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    temp_d      = temp_q;
    flag_d      = flag_q;
    data_d      = data_q;
    sat_d       = sat_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = req_k;
          flag_d      = req_over;
          temp_d      = '0;
          state_d     = (req_k != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        temp_d      = {temp_q[data_width-2:0], 1'b1};
        remaining_d = remaining_q - count_width'(1);
        if (remaining_q == count_width'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        data_d  = temp_q;
        sat_d   = flag_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      temp_q      <= '0;
      flag_q      <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      temp_q      <= temp_d;
      flag_q      <= flag_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
    end
  end

  assign bus.data = data_q;
  assign bus.sat  = sat_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ones_thermo_gen_d.sv
// Scoreboard bench for ones_thermo_gen_d: expectations are queued at request time
// and retired by a monitor on every done pulse.
module tb_ones_thermo_gen_d;

  localparam int DW = 4;
  localparam int CW = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
    int            cyc;
    int            pop;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  ones_thermo_gen_d_if #(.data_width(DW), .count_width(CW)) bus ();

  ones_thermo_gen_d #(.data_width(DW), .count_width(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Retire one expectation per done pulse; a pulse with nothing queued is spurious.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", 32'(bus.data), 32'(e.data));
        check("sat", 32'(bus.sat), 32'(e.sat));
        check("latency", 32'(cyc), 32'(e.cyc));
        check("popcount", 32'($countones(bus.data)), 32'(e.pop));
      end
    end
  end

  // Called at a negedge where the DUT is idle (or in its done cycle).
  task automatic req(input int cnt);
    int   k;
    exp_t e;
    k      = (cnt > DW) ? DW : cnt;
    e.data = DW'((1 << k) - 1);
    e.sat  = (cnt > DW);
    e.cyc  = cyc + k + 2;
    e.pop  = k;
    sb.push_back(e);
    bus.start     = 1'b1;
    bus.bit_count = CW'(cnt);
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_early", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_count = '0;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);

    req(3);
    @(negedge clk);
    check("done_clears", 32'(bus.done), 32'd0);
    check("data_holds", 32'(bus.data), 32'h7);
    req(0);
    req(7);
    req(4);

    // Second start while busy must be dropped.
    @(negedge clk);
    sb.push_back('{data: 4'b0011, sat: 1'b0, cyc: cyc + 4, pop: 2});
    bus.start     = 1'b1;
    bus.bit_count = 3'd2;
    @(negedge clk);
    bus.bit_count = 3'd1;
    check("busy_ign0", 32'(bus.busy), 32'd1);
    check("data_held_busy", 32'(bus.data), 32'hf);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_ign1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_ign2", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("done_ign", 32'(bus.done), 32'd1);
    req(1);

    // Asynchronous abort in the middle of a shift.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bit_count = 3'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_data", 32'(bus.data), 32'd0);
    check("abort_sat", 32'(bus.sat), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_abort_idle", 32'(bus.done), 32'd0);
    req(2);

    // Every count, then random counts, back to back from the done cycle.
    for (int c = 0; c < 8; c++) req(c);
    for (int n = 0; n < 24; n++) req(int'($urandom_range(7, 0)));

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
